// File: rtl/osc_pkg.sv
// Shared definitions for the oscillator family: noise mode encoding, LFSR
// geometry and the single-step LFSR function used by every noise channel.
package osc_pkg;

  typedef enum logic {
    NOISE_LONG  = 1'b0,
    NOISE_SHORT = 1'b1
  } noise_mode_t;

  localparam int                      NOISE_LFSR_W    = 15;
  localparam logic [NOISE_LFSR_W-1:0] NOISE_SEED      = 15'h7FFF;
  localparam int                      NOISE_SHORT_TAP = 6;

  // x^15+x^14+1; short mode folds the feedback into bit 6 for a 127-step loop.
  function automatic logic [NOISE_LFSR_W-1:0] noise_lfsr_next(
    input logic [NOISE_LFSR_W-1:0] s,
    input noise_mode_t             m
  );
    logic                    fb;
    logic [NOISE_LFSR_W-1:0] n;
    fb = s[0] ^ s[1];
    n  = {fb, s[NOISE_LFSR_W-1:1]};
    if (m == NOISE_SHORT) begin
      n[NOISE_SHORT_TAP] = fb;
    end
    return n;
  endfunction

endpackage

// File: rtl/noise_lfsr_ch.sv
// One noise channel: period down-counter, 15-bit LFSR and the registered
// signed sample (+amp or -amp depending on the LFSR output bit).
module noise_lfsr_ch
  import osc_pkg::*;
#(
  parameter int SAMPLE_W = 17,
  parameter int PERIOD_W = 17,
  parameter int VOL_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  noise_mode_t         mode,
  input  logic [VOL_W-1:0]    vol,
  input  logic                retrig,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int AMP_SH = SAMPLE_W - 1 - VOL_W;

  logic [NOISE_LFSR_W-1:0] lfsr;
  logic [NOISE_LFSR_W-1:0] lfsr_nxt;
  logic [PERIOD_W-1:0]     cnt;
  logic [PERIOD_W-1:0]     reload;
  logic [SAMPLE_W-1:0]     amp;
  logic [SAMPLE_W-1:0]     amp_neg;

  // A zero period is treated as one so the counter never wraps.
  always_comb begin
    reload = '0;
    if (period != '0) begin
      reload = period - PERIOD_W'(1);
    end
  end

  always_comb begin
    lfsr_nxt = noise_lfsr_next(lfsr, mode);
  end

  always_comb begin
    amp     = SAMPLE_W'(vol) << AMP_SH;
    amp_neg = -amp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr   <= NOISE_SEED;
      cnt    <= '0;
      sample <= '0;
    end else begin
      // The sample follows the current LFSR and volume even while en is low.
      sample <= lfsr[0] ? amp_neg : amp;
      if (retrig) begin
        lfsr <= NOISE_SEED;
        cnt  <= reload;
      end else if (en) begin
        if (cnt == '0) begin
          lfsr <= lfsr_nxt;
          cnt  <= reload;
        end else begin
          cnt <= cnt - PERIOD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/osc_noise_multi.sv
// Multi-channel LFSR noise oscillator: NUM_CH independent noise channels and
// a registered mix equal to the channel sum scaled down by log2(NUM_CH).
module osc_noise_multi
  import osc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 17,
  parameter int PERIOD_W = 17,
  parameter int VOL_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_CH*PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]          mode,
  input  logic [NUM_CH*VOL_W-1:0]    vol,
  input  logic [NUM_CH-1:0]          retrig,
  output logic [NUM_CH*SAMPLE_W-1:0] sample_ch,
  output logic [SAMPLE_W-1:0]        sample_mix
);

  localparam int LOG2_CH = $clog2(NUM_CH);
  localparam int SUM_W   = SAMPLE_W + LOG2_CH;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    noise_lfsr_ch #(
      .SAMPLE_W (SAMPLE_W),
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .period (period[g*PERIOD_W +: PERIOD_W]),
      .mode   (noise_mode_t'(mode[g])),
      .vol    (vol[g*VOL_W +: VOL_W]),
      .retrig (retrig[g]),
      .sample (sample_ch[g*SAMPLE_W +: SAMPLE_W])
    );
  end

  logic signed [SUM_W-1:0] mix_sum;
  logic signed [SUM_W-1:0] mix_scaled;

  // The widened sum cannot overflow, so the scaled result always fits SAMPLE_W.
  always_comb begin
    logic signed [SAMPLE_W-1:0] s;
    mix_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      s       = sample_ch[i*SAMPLE_W +: SAMPLE_W];
      mix_sum = mix_sum + SUM_W'(s);
    end
    mix_scaled = mix_sum >>> LOG2_CH;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_mix <= '0;
    end else begin
      sample_mix <= mix_scaled[SAMPLE_W-1:0];
    end
  end

endmodule

// File: tb/tb_osc_noise_multi.sv
// Bench for osc_noise_multi: vector table, directed corner sequences and
// randomized traffic, all checked against an arithmetic reference model.
module tb_osc_noise_multi;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 17;
  localparam int PERIOD_W = 17;
  localparam int VOL_W    = 4;
  localparam int AMP_SH   = SAMPLE_W - 1 - VOL_W;
  localparam int SEED     = 32767;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       en;
  logic [NUM_CH*PERIOD_W-1:0] period;
  logic [NUM_CH-1:0]          mode;
  logic [NUM_CH*VOL_W-1:0]    vol;
  logic [NUM_CH-1:0]          retrig;
  logic [NUM_CH*SAMPLE_W-1:0] sample_ch;
  logic [SAMPLE_W-1:0]        sample_mix;

  osc_noise_multi #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .PERIOD_W (PERIOD_W),
    .VOL_W    (VOL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .period     (period),
    .mode       (mode),
    .vol        (vol),
    .retrig     (retrig),
    .sample_ch  (sample_ch),
    .sample_mix (sample_mix)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [SAMPLE_W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int m_lfsr [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_samp [NUM_CH];
  int m_mix;

  function automatic int ref_step(input int s, input bit short_m);
    int fb;
    int n;
    fb = (s ^ (s >> 1)) & 1;
    n  = (s >> 1) | (fb << 14);
    if (short_m) n = (n & ~(1 << 6)) | (fb << 6);
    return n;
  endfunction

  task automatic model_edge();
    int sum;
    int p;
    int amp;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) sum += m_samp[i];
    if (!rst) begin
      m_mix = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_lfsr[i] = SEED;
        m_cnt[i]  = 0;
        m_samp[i] = 0;
      end
    end else begin
      m_mix = sum / NUM_CH;
      if (sum < 0 && (sum % NUM_CH) != 0) m_mix = m_mix - 1;
      for (int i = 0; i < NUM_CH; i++) begin
        p = int'(period[i*PERIOD_W +: PERIOD_W]);
        if (p == 0) p = 1;
        amp = int'(vol[i*VOL_W +: VOL_W]) * (1 << AMP_SH);
        m_samp[i] = (m_lfsr[i] % 2 == 1) ? -amp : amp;
        if (retrig[i]) begin
          m_lfsr[i] = SEED;
          m_cnt[i]  = p - 1;
        end else if (en) begin
          if (m_cnt[i] == 0) begin
            m_lfsr[i] = ref_step(m_lfsr[i], mode[i]);
            m_cnt[i]  = p - 1;
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) exp_q.push_back(SAMPLE_W'(m_samp[i]));
    exp_q.push_back(SAMPLE_W'(m_mix));
  endtask

  task automatic check(input string name, input logic [SAMPLE_W-1:0] act,
                       input logic [SAMPLE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("sample_ch%0d", i), sample_ch[i*SAMPLE_W +: SAMPLE_W], exp_q.pop_front());
    check("sample_mix", sample_mix, exp_q.pop_front());
  endtask

  task automatic set_ch(input int i, input int p, input bit m, input int v);
    period[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(p);
    mode[i]                        = m;
    vol[i*VOL_W +: VOL_W]          = VOL_W'(v);
  endtask

  task automatic set_all(input int p, input bit m, input int v);
    for (int i = 0; i < NUM_CH; i++) set_ch(i, p, m, v);
  endtask

  function automatic logic [SAMPLE_W-1:0] abs_s(input logic [SAMPLE_W-1:0] x);
    logic signed [SAMPLE_W-1:0] s;
    s = x;
    return (s < 0) ? SAMPLE_W'(-s) : x;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit rst;
    bit en;
    int exp_s0;
    int exp_mix;
  } vec_t;

  vec_t vt[8];

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_lfsr[i] = SEED; m_cnt[i] = 0; m_samp[i] = 0;
    end
    m_mix  = 0;
    rst    = 1'b0;
    en     = 1'b1;
    retrig = '0;
    set_all(1, 1'b0, 15);

    // Reset, run, mid-run reset, hold: all channels identical at vol 15.
    vt[0] = '{0, 1, 0, 0};
    vt[1] = '{1, 1, -61440, 0};
    vt[2] = '{1, 1, -61440, -61440};
    vt[3] = '{1, 1, -61440, -61440};
    vt[4] = '{0, 1, 0, 0};
    vt[5] = '{1, 1, -61440, 0};
    vt[6] = '{1, 0, -61440, -61440};
    vt[7] = '{1, 1, -61440, -61440};
    for (int k = 0; k < 8; k++) begin
      rst = vt[k].rst;
      en  = vt[k].en;
      tick();
      check($sformatf("tbl%0d_s0", k), sample_ch[SAMPLE_W-1:0], SAMPLE_W'(vt[k].exp_s0));
      check($sformatf("tbl%0d_mix", k), sample_mix, SAMPLE_W'(vt[k].exp_mix));
    end

    // Period 4 on ch0, period 0 vs 1 on ch1/ch2, long run past the first fb=1.
    set_ch(0, 4, 1'b0, 15);
    set_ch(1, 0, 1'b0, 15);
    set_ch(2, 1, 1'b0, 15);
    set_ch(3, 3, 1'b1, 9);
    retrig = 4'b1111;
    tick();
    retrig = '0;
    repeat (120) tick();

    // Hold for 10 clocks, then a volume change during the hold.
    en = 1'b0;
    repeat (10) tick();
    set_ch(0, 4, 1'b0, 8);
    tick();
    check("hold_vol8_abs", abs_s(sample_ch[SAMPLE_W-1:0]), SAMPLE_W'(32768));
    repeat (3) tick();

    // Retrig ch2 while en=0 and its counter is zero (period 1).
    retrig[2] = 1'b1;
    tick();
    retrig = '0;
    tick();
    en = 1'b1;
    repeat (40) tick();

    // Two in-phase channels at vol 15, two silent ones; then mid-run reset.
    rst = 1'b0;
    tick();
    set_ch(0, 2, 1'b0, 15);
    set_ch(1, 2, 1'b0, 15);
    set_ch(2, 2, 1'b0, 0);
    set_ch(3, 5, 1'b1, 0);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k >= 2) check("mix_inphase_abs", abs_s(sample_mix), SAMPLE_W'(30720));
    end
    rst = 1'b0;
    tick();
    check("rst_mix", sample_mix, '0);
    check("rst_s1", sample_ch[SAMPLE_W +: SAMPLE_W], '0);
    rst = 1'b1;

    // Full long-mode cycle on ch0 and several short-mode cycles on ch1.
    set_all(1, 1'b0, 15);
    set_ch(1, 1, 1'b1, 7);
    retrig = 4'b0011;
    tick();
    retrig = '0;
    repeat (32767 + 20) tick();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) != 0);
      en  = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NUM_CH; i++) begin
        retrig[i] = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 29) == 0)
          set_ch(i, $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
